// File: rtl/seq_pkg.sv
// ============================================================================
// Module : seq_pkg
// Brief  : State encodings and constants shared by sequence generators/detectors.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    typedef enum logic [1:0] {
        GEN_IDLE  = 2'd0,
        GEN_SHIFT = 2'd1,
        GEN_GAP   = 2'd2,
        GEN_DONE  = 2'd3
    } gen_state_e;

    localparam logic [3:0] SEQ_PAT_1011 = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/prbs7_lfsr.sv
// ============================================================================
// Module : prbs7_lfsr
// Brief  : PRBS7 (x^7+x^6+1) source, seed 7'h7F; registered serial output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs7_lfsr (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic bit_out
);

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;
    logic       bit_out_q;
    logic       bit_out_d;

    // Output is retimed so the stream reads 0 while reset is asserted.
    always_comb begin
        lfsr_d    = lfsr_q;
        bit_out_d = bit_out_q;
        if (en) begin
            lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
            bit_out_d = lfsr_q[6];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q    <= 7'h7F;
            bit_out_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            bit_out_q <= bit_out_d;
        end
    end

    assign bit_out = bit_out_q;

endmodule

`default_nettype wire

// File: rtl/moore_seq_generator.sv
// ============================================================================
// Module : moore_seq_generator
// Brief  : Moore serial pattern transmitter, MSB first, with repeats and gaps.
//          Define SEQ_GEN_PRBS_EN for PRBS7 filler instead of constant 0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module moore_seq_generator
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    output logic             x_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int              CNT_W    = $clog2(PAT_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

    gen_state_e       state_q,   state_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [PAT_W-1:0] shreg_q,   shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [GAP_W-1:0] gap_reg_q, gap_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             w_filler;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        rep_cnt_d = rep_cnt_q;
        gap_reg_d = gap_reg_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            GEN_IDLE: begin
                if (start) begin
                    pat_d     = pat_in;
                    shreg_d   = pat_in;
                    rep_cnt_d = (reps == '0) ? REP_W'(1) : reps;
                    gap_reg_d = gap;
                    bit_cnt_d = BIT_LAST;
                    state_d   = GEN_SHIFT;
                end
            end
            GEN_SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_q == '0) begin
                    if (rep_cnt_q == REP_W'(1)) begin
                        state_d   = GEN_DONE;
                        bit_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        shreg_d   = pat_q;
                        bit_cnt_d = BIT_LAST;
                        if (gap_reg_q != '0) begin
                            state_d   = GEN_GAP;
                            gap_cnt_d = gap_reg_q;
                        end
                    end
                end
            end
            GEN_GAP: begin
                // Entered with gap_cnt >= 1, so this dwells exactly gap_reg cycles.
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = GEN_SHIFT;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            GEN_DONE: begin
                state_d = GEN_IDLE;
            end
            default: begin
                state_d = GEN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= GEN_IDLE;
            pat_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            gap_reg_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            gap_reg_q <= gap_reg_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef SEQ_GEN_PRBS_EN
    logic w_prbs_bit;

    prbs7_lfsr u_prbs7_lfsr (
        .clk     (clk),
        .reset   (reset),
        .en      (1'b1),
        .bit_out (w_prbs_bit)
    );

    assign w_filler = w_prbs_bit;
`else
    assign w_filler = 1'b0;
`endif

    // Pure state decode: no input reaches any output combinationally.
    assign bit_valid = (state_q == GEN_SHIFT);
    assign busy      = (state_q != GEN_IDLE);
    assign done      = (state_q == GEN_DONE);
    assign x_out     = (state_q == GEN_SHIFT) ? shreg_q[PAT_W-1] : w_filler;

endmodule

`default_nettype wire

// File: tb/tb_moore_seq_generator.sv
// ============================================================================
// Module : tb_moore_seq_generator
// Brief  : Self-checking bench for moore_seq_generator (random + directed).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_moore_seq_generator;

    localparam int PAT_W = 4;
    localparam int REP_W = 4;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [REP_W-1:0] reps = '0;
    logic [GAP_W-1:0] gap = '0;
    logic             x_out;
    logic             bit_valid;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic valid;
        logic xbit;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    logic obs_q[$];

    moore_seq_generator #(
        .PAT_W (PAT_W),
        .REP_W (REP_W),
        .GAP_W (GAP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_in    (pat_in),
        .reps      (reps),
        .gap       (gap),
        .x_out     (x_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

`ifdef SEQ_GEN_PRBS_EN
    logic prbs_seq [127];
    int   cyc;

    initial begin
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < 127; i++) begin
            prbs_seq[i] = s[6];
            s = {s[5:0], s[6] ^ s[5]};
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic filler();
        return (cyc == 0) ? 1'b0 : prbs_seq[(cyc - 1) % 127];
    endfunction
`else
    function automatic logic filler();
        return 1'b0;
    endfunction
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected busy window: reps frames, gaps between them, one done cycle.
    task automatic build(input logic [PAT_W-1:0] p, input int r, input int g);
        int n;
        exp_q.delete();
        n = (r == 0) ? 1 : r;
        for (int k = 0; k < n; k++) begin
            for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back('{1'b1, p[b], 1'b0});
            if (k < n - 1)
                for (int j = 0; j < g; j++) exp_q.push_back('{1'b0, 1'b0, 1'b0});
        end
        exp_q.push_back('{1'b0, 1'b0, 1'b1});
    endtask

    task automatic start_frame(input logic [PAT_W-1:0] p, input int r, input int g);
        pat_in = p;
        reps   = REP_W'(r);
        gap    = GAP_W'(g);
        build(p, r, g);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input bit disturb);
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [3:0] want;
            logic [3:0] got;
            want = {1'b1, exp_q[i].valid, exp_q[i].done,
                    exp_q[i].valid ? exp_q[i].xbit : filler()};
            got  = {busy, bit_valid, done, x_out};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s cycle %0d: busy/valid/done/x got=%b want=%b", tag, i, got, want);
            end
            if (bit_valid === 1'b1) obs_q.push_back(x_out);
            if (disturb && i == 1) begin
                start  = 1'b1;
                pat_in = ~pat_in;
                reps   = 4'd7;
                gap    = 4'd5;
            end
            if (disturb && i == 2) start = 1'b0;
            tick();
        end
    endtask

    task automatic expect_idle(input string tag);
        logic [3:0] want;
        logic [3:0] got;
        want = {3'b000, filler()};
        got  = {busy, bit_valid, done, x_out};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: busy/valid/done/x got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, bit_valid, done, x_out} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_state: got=%b want=0000", {busy, bit_valid, done, x_out});
        end
        reset = 1'b0;
        tick();
        expect_idle("reset_release_idle");
    endtask

    task automatic test_single();
        start_frame(4'b1011, 1, 0);
        expect_frame("single_1011", 1'b0);
        expect_idle("single_after_done");
        tick();
        expect_idle("single_idle2");
    endtask

    task automatic test_repeat_gap();
        start_frame(4'b1011, 2, 2);
        total++;
        if (exp_q.size() != 11) begin
            bad++;
            $display("FAIL gap_model_len: got=%0d want=11", exp_q.size());
        end
        expect_frame("reps2_gap2", 1'b0);
        expect_idle("reps2_gap2_after");
    endtask

    task automatic test_detect();
        int hits;
        obs_q.delete();
        start_frame(4'b1011, 3, 0);
        expect_frame("reps3_gap0", 1'b0);
        hits = 0;
        for (int i = 0; i + 4 <= obs_q.size(); i++)
            if ({obs_q[i], obs_q[i+1], obs_q[i+2], obs_q[i+3]} == 4'b1011) hits++;
        total++;
        if (hits != 3 || obs_q.size() != 12) begin
            bad++;
            $display("FAIL detect_1011: hits=%0d bits=%0d want hits=3 bits=12", hits, obs_q.size());
        end
    endtask

    task automatic test_reps_zero_ignore();
        start_frame(4'b1101, 0, 3);
        expect_frame("reps0_disturbed", 1'b1);
        expect_idle("reps0_after");
    endtask

    task automatic test_back_to_back();
        pat_in = 4'b1011;
        reps   = 4'd1;
        gap    = 4'd0;
        build(4'b1011, 1, 0);
        start = 1'b1;
        tick();
        expect_frame("b2b_first", 1'b0);
        expect_idle("b2b_idle_between");
        pat_in = 4'b0110;
        build(4'b0110, 1, 0);
        tick();
        start = 1'b0;
        expect_frame("b2b_second", 1'b0);
        expect_idle("b2b_after");
        tick();
        expect_idle("b2b_no_restart");
    endtask

    task automatic test_reset_mid();
        int saw_done;
        start_frame(4'b1011, 1, 0);
        tick();
        reset = 1'b1;
        #1;
        total++;
        if ({busy, bit_valid, x_out} !== 3'b000) begin
            bad++;
            $display("FAIL reset_mid_async: busy/valid/x got=%b want=000", {busy, bit_valid, x_out});
        end
        tick();
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) saw_done++;
        end
        total++;
        if (saw_done != 0) begin
            bad++;
            $display("FAIL reset_mid_no_done: active cycles got=%0d want=0", saw_done);
        end
        start_frame(4'b1011, 1, 0);
        expect_frame("after_reset_mid", 1'b0);
        expect_idle("after_reset_mid_idle");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [PAT_W-1:0] p;
            int r;
            int g;
            p = PAT_W'($urandom);
            r = int'($urandom_range(0, 3));
            g = int'($urandom_range(0, 3));
            start_frame(p, r, g);
            expect_frame($sformatf("rand%0d_p%b_r%0d_g%0d", n, p, r, g), 1'($urandom));
            expect_idle($sformatf("rand%0d_idle", n));
            repeat (int'($urandom_range(0, 2))) begin
                tick();
                expect_idle($sformatf("rand%0d_idle_extra", n));
            end
        end
    endtask

    task automatic test_idle_filler();
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_idle($sformatf("idle_filler%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_detect();
        test_reps_zero_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_idle_filler();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
